clk_period_meter: RTL and testbench

Measures the period and high time of a slow, asynchronous square wave, such as the output of the team's programmable clock divider, in cycles of the system clock. This is the checking end of the divider: it confirms the divided clock actually runs at the programmed ratio. It reports each completed period with a one-cycle valid strobe, flags a stalled input, and asserts lock once consecutive periods match.

---
 rtl/clk_meter_pkg.sv | 13 +
 rtl/edge_sync.sv | 33 +++
 rtl/clk_period_meter.sv | 103 ++++++++++
 tb/tb_clk_period_meter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/clk_meter_pkg.sv
// Shared types for the clock period meter.
// FSM state encoding and default counter width.
package clk_meter_pkg;

  localparam int DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer plus delay flop.
// Emits single-cycle rise/fall strobes.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  // s1/s2 resolve metastability, s3 holds the previous level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow async square wave.
// Publishes with a valid strobe, flags stall, tracks lock.
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = 2**WIDTH - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             meas_in,
  input  logic             enable,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             stuck,
  output logic             lock
);

  localparam logic [WIDTH-1:0] TMO = TIMEOUT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] hi_shadow;
  logic             have_prev;
  logic             lvl;
  logic             rise;
  logic             fall;

  edge_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (meas_in),
    .level (lvl),
    .rise  (rise),
    .fall  (fall)
  );

  // FSM, counter, shadow and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      hi_shadow <= '0;
      have_prev <= 1'b0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      stuck     <= 1'b0;
      lock      <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!enable) begin
        state     <= IDLE;
        cnt       <= '0;
        have_prev <= 1'b0;
        stuck     <= 1'b0;
        lock      <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            cnt   <= '0;
            state <= ARM;
          end
          ARM: begin
            if (rise) begin
              cnt   <= ONE;
              stuck <= 1'b0;
              state <= MEASURE;
            end
          end
          MEASURE: begin
            if (fall) hi_shadow <= cnt;
            if (rise) begin
              period    <= cnt;
              high_time <= hi_shadow;
              valid     <= 1'b1;
              cnt       <= ONE;
              stuck     <= 1'b0;
              lock      <= (cnt == period) && have_prev;
              have_prev <= 1'b1;
            end else if (cnt == TMO) begin
              cnt       <= '0;
              stuck     <= 1'b1;
              lock      <= 1'b0;
              have_prev <= 1'b0;
              state     <= ARM;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // synchronized level is only needed by other users of edge_sync
  logic unused_lvl;
  assign unused_lvl = lvl;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter.
// WIDTH=5, TIMEOUT=20.
module tb_clk_period_meter;

  logic       clk;
  logic       rst_n;
  logic       meas_in;
  logic       enable;
  logic [4:0] period;
  logic [4:0] high_time;
  logic       valid;
  logic       stuck;
  logic       lock;

  clk_period_meter #(.WIDTH(5), .TIMEOUT(20)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .meas_in   (meas_in),
    .enable    (enable),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .stuck     (stuck),
    .lock      (lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int h;
    int l;
    int nv;
    int per;
    int hi;
    int lk;
    int ss;
    int se;
  } row_t;

  typedef struct {
    int p;
    int h;
    int l;
  } rec_t;

  row_t tbl[24];
  rec_t q[$];
  int   stuck_seen;
  int   total;
  int   bad;

  always @(negedge clk) begin
    if (valid) q.push_back('{int'(period), int'(high_time), int'(lock)});
    if (stuck) stuck_seen = 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_row(input int i);
    string nm;
    row_t  r;
    r  = tbl[i];
    nm = $sformatf("row%0d", i);
    q.delete();
    stuck_seen = 0;
    meas_in = 1'b1;
    cyc(r.h);
    meas_in = 1'b0;
    cyc(r.l);
    chk({nm, ".nvalid"}, q.size(), r.nv);
    if (r.nv > 0 && q.size() > 0) begin
      chk({nm, ".period"}, q[0].p, r.per);
      chk({nm, ".high"}, q[0].h, r.hi);
      chk({nm, ".lock"}, q[0].l, r.lk);
    end
    chk({nm, ".stuck_seen"}, stuck_seen, r.ss);
    chk({nm, ".stuck_end"}, int'(stuck), r.se);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) run_row(i);
  endtask

  int vc;
  int sc;
  int nv;
  int pv;

  initial begin
    //             h   l nv per hi lk ss se
    tbl[0]  = '{ 4,  4, 0,  0, 0, 0, 0, 0};
    tbl[1]  = '{ 4,  4, 1,  8, 4, 0, 0, 0};
    tbl[2]  = '{ 4,  4, 1,  8, 4, 1, 0, 0};
    tbl[3]  = '{ 3,  5, 1,  8, 4, 1, 0, 0};
    tbl[4]  = '{ 3,  5, 1,  8, 3, 1, 0, 0};
    tbl[5]  = '{ 5,  5, 1,  8, 3, 1, 0, 0};
    tbl[6]  = '{ 5,  5, 1, 10, 5, 0, 0, 0};
    tbl[7]  = '{ 5,  5, 1, 10, 5, 1, 0, 0};
    tbl[8]  = '{ 4,  4, 0,  0, 0, 0, 1, 0};
    tbl[9]  = '{ 4,  4, 1,  8, 4, 0, 0, 0};
    tbl[10] = '{ 4,  4, 1,  8, 4, 1, 0, 0};
    tbl[11] = '{10, 10, 1,  8, 4, 1, 0, 0};
    tbl[12] = '{10, 10, 1, 20,10, 0, 0, 0};
    tbl[13] = '{10, 11, 1, 20,10, 1, 0, 0};
    tbl[14] = '{ 4,  4, 0,  0, 0, 0, 1, 0};
    tbl[15] = '{ 4,  4, 1,  8, 4, 0, 0, 0};
    tbl[16] = '{ 4,  4, 1,  8, 4, 1, 0, 0};
    tbl[17] = '{ 4,  4, 0,  0, 0, 0, 0, 0};
    tbl[18] = '{ 4,  4, 1,  8, 4, 0, 0, 0};
    tbl[19] = '{ 4,  4, 1,  8, 4, 1, 0, 0};
    tbl[20] = '{ 4,  4, 0,  0, 0, 0, 0, 0};
    tbl[21] = '{ 4,  4, 1,  8, 4, 0, 0, 0};
    tbl[22] = '{ 4,  4, 0,  0, 0, 0, 0, 0};
    tbl[23] = '{ 4,  4, 0,  0, 0, 0, 0, 0};
    total = 0;
    bad = 0;
    stuck_seen = 0;
    rst_n = 1'b0;
    enable = 1'b0;
    meas_in = 1'b0;

    #3;
    chk("rst.period", int'(period), 0);
    chk("rst.high", int'(high_time), 0);
    chk("rst.valid", int'(valid), 0);
    chk("rst.stuck", int'(stuck), 0);
    chk("rst.lock", int'(lock), 0);
    #7;
    rst_n = 1'b1;
    cyc(1);
    enable = 1'b1;
    cyc(2);

    // basic, duty change, ratio change
    run_rows(0, 7);

    // stall: stuck must follow the last valid by 20 cycles
    vc = -1;
    sc = -1;
    nv = 0;
    pv = -1;
    meas_in = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (i == 5) meas_in = 1'b0;
      if (valid) begin
        vc = i;
        nv++;
        pv = int'(period);
      end
      if (stuck) begin
        sc = i;
        break;
      end
    end
    chk("to.stuck_seen", int'(sc > 0), 1);
    chk("to.nvalid", nv, 1);
    chk("to.period", pv, 10);
    chk("to.spacing", sc - vc, 20);
    chk("to.lock", int'(lock), 0);
    cyc(3);
    chk("to.stuck_hold", int'(stuck), 1);
    chk("to.valid_none", int'(valid), 0);

    // recovery, period 20 boundary, period 21 timeout
    run_rows(8, 16);

    // disable mid-period
    meas_in = 1'b1;
    cyc(4);
    meas_in = 1'b0;
    cyc(2);
    chk("dis.lock_before", int'(lock), 1);
    q.delete();
    enable = 1'b0;
    cyc(2);
    meas_in = 1'b1;
    cyc(4);
    meas_in = 1'b0;
    cyc(4);
    chk("dis.nvalid", q.size(), 0);
    chk("dis.lock", int'(lock), 0);
    chk("dis.stuck", int'(stuck), 0);
    chk("dis.period", int'(period), 8);
    chk("dis.high", int'(high_time), 4);
    enable = 1'b1;
    cyc(1);
    run_rows(17, 19);

    // async reset mid-measurement
    meas_in = 1'b1;
    cyc(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.period", int'(period), 0);
    chk("arst.high", int'(high_time), 0);
    chk("arst.valid", int'(valid), 0);
    chk("arst.lock", int'(lock), 0);
    chk("arst.stuck", int'(stuck), 0);
    meas_in = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    run_rows(20, 21);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
